starfield_mixer: RTL and testbench

STARFIELD_MIXER -- requirements
Module: starfield_mixer

---
 rtl/starfield_mixer.sv | 236 +++++++++++++++++++++++
 tb/tb_starfield_mixer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/starfield_mixer.sv
// starfield_mixer: merges three starfield layers into a 4-bit-per-channel VGA
// pixel, scaled by a frame-paced fade level, through a two-stage pipeline.
// Optional build macro: STARFIELD_MIXER_TINT_EN (layer 3 stars drawn bluish).
module starfield_mixer #(
    parameter int FADE_STEP = 4
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic       frame,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       de,
    input  logic       sf1_on,
    input  logic       sf2_on,
    input  logic       sf3_on,
    input  logic [7:0] sf1_star,
    input  logic [7:0] sf2_star,
    input  logic [7:0] sf3_star,
    input  logic       show,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       fade_busy
);

    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_FADE_IN  = 2'd1,
        S_ON       = 2'd2,
        S_FADE_OUT = 2'd3
    } state_t;

    // Last value of the step counter within one step period.
    localparam logic [7:0] STEP_LAST = 8'(FADE_STEP - 1);

    // Fade controller state
    state_t     r_state;
    logic [3:0] r_level;
    logic [7:0] r_step_cnt;
    logic       r_fade_busy;
    logic [7:0] w_cnt_adv;
    logic       w_step;

    // Stage 1 registers
    logic       r_hs1;
    logic       r_vs1;
    logic       r_de1;
    logic [3:0] r_star1;
`ifdef STARFIELD_MIXER_TINT_EN
    logic [1:0] r_layer1;
`endif

    // Stage 2 (output) registers
    logic       r_vga_hs;
    logic       r_vga_vs;
    logic [3:0] r_vga_r;
    logic [3:0] r_vga_g;
    logic [3:0] r_vga_b;

    // Combinational helpers
    logic [3:0] w_star_sel;
    logic [1:0] w_layer_sel;
    logic [7:0] w_product;
    logic [3:0] w_scaled;
    logic [3:0] w_r;
    logic [3:0] w_g;
    logic [3:0] w_b;
    logic       w_unused;

    // Step counter advance: the counter value on a fade pulse walks
    // 0..FADE_STEP-1; landing on the last value is a step.
    assign w_cnt_adv = (r_step_cnt == STEP_LAST) ? 8'd0 : r_step_cnt + 8'd1;
    assign w_step    = (w_cnt_adv == STEP_LAST);

    // Layer priority: nearest layer (1) wins, only the top nibble is used.
    always_comb begin
        w_star_sel  = 4'd0;
        w_layer_sel = 2'd0;
        if (sf1_on) begin
            w_star_sel  = sf1_star[7:4];
            w_layer_sel = 2'd1;
        end else if (sf2_on) begin
            w_star_sel  = sf2_star[7:4];
            w_layer_sel = 2'd2;
        end else if (sf3_on) begin
            w_star_sel  = sf3_star[7:4];
            w_layer_sel = 2'd3;
        end
    end

    // Brightness scaling: full level passes the star through untouched so
    // that 15 gives the true brightness rather than 15/16 of it.
    assign w_product = {4'd0, r_star1} * {4'd0, r_level};
    assign w_scaled  = (r_level == 4'hF) ? r_star1 : w_product[7:4];

    // Colour formation, blanked outside the active area.
    always_comb begin
        w_r = 4'd0;
        w_g = 4'd0;
        w_b = 4'd0;
        if (r_de1) begin
            w_r = w_scaled;
            w_g = w_scaled;
            w_b = w_scaled;
`ifdef STARFIELD_MIXER_TINT_EN
            if (r_layer1 == 2'd3) begin
                w_r = {1'b0, w_scaled[3:1]};
                w_g = {1'b0, w_scaled[3:1]};
            end
`endif
        end
    end

`ifdef STARFIELD_MIXER_TINT_EN
    assign w_unused = ^{sf1_star[3:0], sf2_star[3:0], sf3_star[3:0], w_product[3:0]};
`else
    assign w_unused = ^{sf1_star[3:0], sf2_star[3:0], sf3_star[3:0], w_product[3:0],
                        w_layer_sel};
`endif

    // Fade FSM: advances only on frame pulses; a show reversal overrides a
    // coincident step so the level never jumps on a direction change.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_state     <= S_OFF;
            r_level     <= 4'd0;
            r_step_cnt  <= 8'd0;
            r_fade_busy <= 1'b0;
        end else if (frame) begin
            case (r_state)
                S_OFF: begin
                    r_level <= 4'd0;
                    if (show) begin
                        r_state     <= S_FADE_IN;
                        r_step_cnt  <= 8'd0;
                        r_fade_busy <= 1'b1;
                    end
                end
                S_FADE_IN: begin
                    r_step_cnt <= w_cnt_adv;
                    if (!show) begin
                        r_state <= S_FADE_OUT;
                    end else if (w_step) begin
                        if (r_level >= 4'd14) begin
                            r_level     <= 4'd15;
                            r_state     <= S_ON;
                            r_fade_busy <= 1'b0;
                        end else begin
                            r_level <= r_level + 4'd1;
                        end
                    end
                end
                S_ON: begin
                    r_level <= 4'd15;
                    if (!show) begin
                        r_state     <= S_FADE_OUT;
                        r_step_cnt  <= 8'd0;
                        r_fade_busy <= 1'b1;
                    end
                end
                S_FADE_OUT: begin
                    r_step_cnt <= w_cnt_adv;
                    if (show) begin
                        r_state <= S_FADE_IN;
                    end else if (w_step) begin
                        if (r_level <= 4'd1) begin
                            r_level     <= 4'd0;
                            r_state     <= S_OFF;
                            r_fade_busy <= 1'b0;
                        end else begin
                            r_level <= r_level - 4'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_OFF;
                    r_level     <= 4'd0;
                    r_fade_busy <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture timing and the selected star.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_de1   <= 1'b0;
            r_star1 <= 4'd0;
        end else begin
            r_hs1   <= hsync;
            r_vs1   <= vsync;
            r_de1   <= de;
            r_star1 <= w_star_sel;
        end
    end

`ifdef STARFIELD_MIXER_TINT_EN
    // Stage 1 layer index, needed only to tint the far layer.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_layer1 <= 2'd0;
        end else begin
            r_layer1 <= w_layer_sel;
        end
    end
`endif

    // Stage 2: scaled colour and syncs; syncs idle high (negative polarity).
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_vga_hs <= 1'b1;
            r_vga_vs <= 1'b1;
            r_vga_r  <= 4'd0;
            r_vga_g  <= 4'd0;
            r_vga_b  <= 4'd0;
        end else begin
            r_vga_hs <= r_hs1;
            r_vga_vs <= r_vs1;
            r_vga_r  <= w_r;
            r_vga_g  <= w_g;
            r_vga_b  <= w_b;
        end
    end

    assign vga_hsync = r_vga_hs;
    assign vga_vsync = r_vga_vs;
    assign vga_r     = r_vga_r;
    assign vga_g     = r_vga_g;
    assign vga_b     = r_vga_b;
    assign fade_busy = r_fade_busy;

endmodule

// File: tb/tb_starfield_mixer.sv
// tb_starfield_mixer: randomized pixel traffic and fade scenarios for
// starfield_mixer, checked against a frame-level fade model.
module tb_starfield_mixer;

    localparam int FADE_STEP = 4;

    localparam int M_OFF = 0;
    localparam int M_IN  = 1;
    localparam int M_ON  = 2;
    localparam int M_OUT = 3;

    logic       clk_pix   = 1'b0;
    logic       rst_pix_n = 1'b1;
    logic       frame     = 1'b0;
    logic       hsync     = 1'b1;
    logic       vsync     = 1'b1;
    logic       de        = 1'b0;
    logic       sf1_on    = 1'b0;
    logic       sf2_on    = 1'b0;
    logic       sf3_on    = 1'b0;
    logic [7:0] sf1_star  = 8'd0;
    logic [7:0] sf2_star  = 8'd0;
    logic [7:0] sf3_star  = 8'd0;
    logic       show      = 1'b0;
    logic       vga_hsync;
    logic       vga_vsync;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       fade_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Fade model: mode, level, and pulses seen since entering a fade.
    int m_mode  = M_OFF;
    int m_level = 0;
    int m_phase = 0;

    // Inputs presented one cycle before the current edge.
    logic       p_hs = 1'b0, p_vs = 1'b0, p_de = 1'b0;
    logic       p_on1 = 1'b0, p_on2 = 1'b0, p_on3 = 1'b0;
    logic [7:0] p_s1 = 8'd0, p_s2 = 8'd0, p_s3 = 8'd0;

    starfield_mixer #(.FADE_STEP(FADE_STEP)) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .frame     (frame),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .sf1_on    (sf1_on),
        .sf2_on    (sf2_on),
        .sf3_on    (sf3_on),
        .sf1_star  (sf1_star),
        .sf2_star  (sf2_star),
        .sf3_star  (sf3_star),
        .show      (show),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .fade_busy (fade_busy)
    );

    always #5 clk_pix = ~clk_pix;

    // Expected colour for one pixel at a given level, straight from the rules.
    function automatic logic [11:0] ref_pixel(input logic d, input logic o1, input logic o2,
                                              input logic o3, input logic [7:0] s1,
                                              input logic [7:0] s2, input logic [7:0] s3,
                                              input int lvl);
        int star;
        int scaled;
        int rc;
        int bc;
        if (o1)      star = int'(s1) / 16;
        else if (o2) star = int'(s2) / 16;
        else if (o3) star = int'(s3) / 16;
        else         star = 0;
        if (lvl == 15) scaled = star;
        else           scaled = ((star * lvl) % 256) / 16;
        if (!d) scaled = 0;
        rc = scaled;
        bc = scaled;
`ifdef STARFIELD_MIXER_TINT_EN
        if (!o1 && !o2 && o3) rc = scaled / 2;
`endif
        return {4'(rc), 4'(rc), 4'(bc)};
    endfunction

    // One frame pulse applied to the fade model.
    task automatic model_frame(input logic sh);
        bit is_step;
        case (m_mode)
            M_OFF: begin
                m_level = 0;
                if (sh) begin
                    m_mode  = M_IN;
                    m_phase = 1;
                end
            end
            M_ON: begin
                m_level = 15;
                if (!sh) begin
                    m_mode  = M_OUT;
                    m_phase = 1;
                end
            end
            default: begin
                m_phase = m_phase + 1;
                is_step = (m_phase % FADE_STEP) == 0;
                if (m_mode == M_IN && !sh) begin
                    m_mode = M_OUT;
                end else if (m_mode == M_OUT && sh) begin
                    m_mode = M_IN;
                end else if (is_step) begin
                    if (m_mode == M_IN) begin
                        m_level = (m_level < 15) ? m_level + 1 : 15;
                        if (m_level == 15) m_mode = M_ON;
                    end else begin
                        m_level = (m_level > 0) ? m_level - 1 : 0;
                        if (m_level == 0) m_mode = M_OFF;
                    end
                end
            end
        endcase
    endtask

    task automatic model_reset();
        m_mode  = M_OFF;
        m_level = 0;
        m_phase = 0;
        p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0;
        p_on1 = 1'b0; p_on2 = 1'b0; p_on3 = 1'b0;
        p_s1 = 8'd0; p_s2 = 8'd0; p_s3 = 8'd0;
    endtask

    // Advance one clock, update the model and compare every output.
    task automatic step_cycle();
        logic [11:0] exp_rgb;
        logic        exp_hs;
        logic        exp_vs;
        logic        exp_busy;
        @(posedge clk_pix);
        exp_rgb = ref_pixel(p_de, p_on1, p_on2, p_on3, p_s1, p_s2, p_s3, m_level);
        exp_hs  = p_hs;
        exp_vs  = p_vs;
        if (frame) model_frame(show);
        exp_busy = (m_mode == M_IN) || (m_mode == M_OUT);
        p_hs = hsync; p_vs = vsync; p_de = de;
        p_on1 = sf1_on; p_on2 = sf2_on; p_on3 = sf3_on;
        p_s1 = sf1_star; p_s2 = sf2_star; p_s3 = sf3_star;
        #1;
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b} !== exp_rgb) begin
            n_errors = n_errors + 1;
            $display("FAIL pixel t=%0t got %h expected %h (level %0d)", $time,
                     {vga_r, vga_g, vga_b}, exp_rgb, m_level);
        end
        n_checks = n_checks + 1;
        if ({vga_hsync, vga_vsync} !== {exp_hs, exp_vs}) begin
            n_errors = n_errors + 1;
            $display("FAIL syncs t=%0t got %b expected %b", $time,
                     {vga_hsync, vga_vsync}, {exp_hs, exp_vs});
        end
        n_checks = n_checks + 1;
        if (fade_busy !== exp_busy) begin
            n_errors = n_errors + 1;
            $display("FAIL fade_busy t=%0t got %b expected %b", $time, fade_busy, exp_busy);
        end
    endtask

    task automatic rand_pixels();
        hsync    = 1'($urandom_range(0, 1));
        vsync    = 1'($urandom_range(0, 1));
        de       = ($urandom_range(0, 3) != 0);
        sf1_on   = ($urandom_range(0, 3) == 0);
        sf2_on   = ($urandom_range(0, 3) == 0);
        sf3_on   = ($urandom_range(0, 2) == 0);
        sf1_star = 8'($urandom);
        sf2_star = 8'($urandom);
        sf3_star = 8'($urandom);
    endtask

    // nf frame pulses, each followed by gap-1 idle cycles, show held at sh.
    task automatic run_frames(input int nf, input logic sh, input int gap);
        show = sh;
        for (int f = 0; f < nf; f++) begin
            for (int c = 0; c < gap; c++) begin
                rand_pixels();
                frame = (c == 0);
                step_cycle();
            end
        end
        frame = 1'b0;
    endtask

    // Present one fixed pixel and let it reach the outputs.
    task automatic hold_pixel(input logic d, input logic o1, input logic o2, input logic o3,
                              input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
        frame = 1'b0;
        de = d; sf1_on = o1; sf2_on = o2; sf3_on = o3;
        sf1_star = s1; sf2_star = s2; sf3_star = s3;
        step_cycle();
        step_cycle();
    endtask

    task automatic test_reset();
        #2 rst_pix_n = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, fade_busy} !== {12'h000, 3'b110}) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_async got rgb=%h hs=%b vs=%b busy=%b required 000/1/1/0",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, fade_busy);
        end
        @(posedge clk_pix);
        @(posedge clk_pix);
        #1;
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, fade_busy} !== {12'h000, 3'b110}) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_hold got rgb=%h hs=%b vs=%b busy=%b required 000/1/1/0",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, fade_busy);
        end
        rst_pix_n = 1'b1;
        model_reset();
        $display("test_reset: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_fade_in();
        run_frames(59, 1'b1, 4);
        n_checks = n_checks + 1;
        if (fade_busy !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL busy_pulse59 got %b required 1", fade_busy);
        end
        run_frames(1, 1'b1, 4);
        n_checks = n_checks + 1;
        if (fade_busy !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL busy_pulse60 got %b required 0", fade_busy);
        end
        hold_pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h00);
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
            n_errors = n_errors + 1;
            $display("FAIL level15_full got %h required fff", {vga_r, vga_g, vga_b});
        end
        $display("test_fade_in: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_priority();
        hold_pixel(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'hC3, 8'($urandom), 8'($urandom));
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b} !== 12'hCCC) begin
            n_errors = n_errors + 1;
            $display("FAIL priority got %h required ccc", {vga_r, vga_g, vga_b});
        end
        $display("test_priority: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_fade_out_reset();
        run_frames(24, 1'b0, 4);
        hold_pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h00);
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b, fade_busy} !== {12'h888, 1'b1}) begin
            n_errors = n_errors + 1;
            $display("FAIL level9 got rgb=%h busy=%b required 888/1", {vga_r, vga_g, vga_b}, fade_busy);
        end
        #2 rst_pix_n = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, fade_busy} !== {12'h000, 3'b110}) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_midfade got rgb=%h hs=%b vs=%b busy=%b required 000/1/1/0",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, fade_busy);
        end
        @(posedge clk_pix);
        #1 rst_pix_n = 1'b1;
        model_reset();
        $display("test_fade_out_reset: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_reversal();
        run_frames(8, 1'b1, 4);
        hold_pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h00);
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b} !== 12'h111) begin
            n_errors = n_errors + 1;
            $display("FAIL restart_level2 got %h required 111", {vga_r, vga_g, vga_b});
        end
        run_frames(16, 1'b1, 4);
        run_frames(3, 1'b1, 4);
        run_frames(1, 1'b0, 4);
        hold_pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h00);
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b, fade_busy} !== {12'h555, 1'b1}) begin
            n_errors = n_errors + 1;
            $display("FAIL reversal_hold got rgb=%h busy=%b required 555/1", {vga_r, vga_g, vga_b}, fade_busy);
        end
        run_frames(4, 1'b0, 4);
        hold_pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h00);
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b} !== 12'h444) begin
            n_errors = n_errors + 1;
            $display("FAIL reversal_level5 got %h required 444", {vga_r, vga_g, vga_b});
        end
        run_frames(19, 1'b0, 4);
        n_checks = n_checks + 1;
        if (fade_busy !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL busy_before_off got %b required 1", fade_busy);
        end
        run_frames(1, 1'b0, 4);
        hold_pixel(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h00);
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b, fade_busy} !== {12'h000, 1'b0}) begin
            n_errors = n_errors + 1;
            $display("FAIL off_after_24 got rgb=%h busy=%b required 000/0", {vga_r, vga_g, vga_b}, fade_busy);
        end
        $display("test_reversal: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_level8();
        run_frames(32, 1'b1, 4);
        hold_pixel(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFA, 8'h00);
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b} !== 12'h777) begin
            n_errors = n_errors + 1;
            $display("FAIL level8 got %h required 777", {vga_r, vga_g, vga_b});
        end
        hold_pixel(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            n_errors = n_errors + 1;
            $display("FAIL de_low got %h required 000", {vga_r, vga_g, vga_b});
        end
        $display("test_level8: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_back_to_back();
        logic sh;
        sh = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) sh = ~sh;
            run_frames(1, sh, int'($urandom_range(1, 3)));
        end
        $display("test_back_to_back: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_tint();
        logic [11:0] exp_rgb;
        run_frames(70, 1'b1, 2);
        hold_pixel(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hE0);
`ifdef STARFIELD_MIXER_TINT_EN
        exp_rgb = 12'h77E;
`else
        exp_rgb = 12'hEEE;
`endif
        n_checks = n_checks + 1;
        if ({vga_r, vga_g, vga_b} !== exp_rgb) begin
            n_errors = n_errors + 1;
            $display("FAIL layer3_colour got %h required %h", {vga_r, vga_g, vga_b}, exp_rgb);
        end
        $display("test_tint: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_priority();
        test_fade_out_reset();
        test_reversal();
        test_level8();
        test_back_to_back();
        test_tint();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
